// File: rtl/signed_block_accumulator.sv
// rtl/signed_block_accumulator.sv - saturating block accumulator of sign-extended samples
//
// Purpose: accepts narrow signed samples over a valid/ready handshake and sign-extends
// each one to p_OUTPUT_WIDTH. It adds p_COUNT samples per block with clamp-and-continue
// saturation, then holds the block sum until the consumer takes it.
//
// Ports:
//   i_CLK       clock, all state on rising edge
//   i_RST_N     synchronous active-low reset
//   i_VALID     sample valid
//   o_READY     block can accept a sample (ACCUM state and not in reset)
//   i_DATA      signed sample, p_INPUT_WIDTH bits
//   o_VALID     block sum valid
//   i_READY     consumer accepts sum
//   o_SUM       signed saturated block sum, p_OUTPUT_WIDTH bits
//   o_OVERFLOW  saturation occurred somewhere in the block, qualified by o_VALID
module signed_block_accumulator #(
   parameter int p_INPUT_WIDTH  = 8,
   parameter int p_OUTPUT_WIDTH = 16,
   parameter int p_COUNT        = 4
) (
   input  logic                      i_CLK,
   input  logic                      i_RST_N,
   input  logic                      i_VALID,
   output logic                      o_READY,
   input  logic [p_INPUT_WIDTH-1:0]  i_DATA,
   output logic                      o_VALID,
   input  logic                      i_READY,
   output logic [p_OUTPUT_WIDTH-1:0] o_SUM,
   output logic                      o_OVERFLOW
);

   localparam int lp_CW = $clog2(p_COUNT + 1);
   localparam int lp_W  = p_OUTPUT_WIDTH;

   localparam logic [0:0] S_ACCUM = 1'b0;
   localparam logic [0:0] S_HOLD  = 1'b1;

   logic [0:0]       r_state;
   logic [lp_W-1:0]  r_acc;
   logic [lp_CW-1:0] r_cnt;
   logic             r_sat;

   logic [lp_W-1:0]  w_ext;
   logic [lp_W:0]    w_tmp;
   logic [lp_W-1:0]  w_clamp;
   logic             w_sat_now;
   logic             w_last;

   assign w_ext = {{(lp_W - p_INPUT_WIDTH){i_DATA[p_INPUT_WIDTH-1]}}, i_DATA};
   assign w_tmp = {r_acc[lp_W-1], r_acc} + {w_ext[lp_W-1], w_ext};

   // The two top bits of the one-bit-wider sum disagree exactly when the true
   // result does not fit in lp_W bits; the extra MSB gives the true sign.
   always_comb begin
      w_clamp   = w_tmp[lp_W-1:0];
      w_sat_now = 1'b0;
      if (w_tmp[lp_W:lp_W-1] == 2'b01) begin
         w_clamp   = {1'b0, {(lp_W-1){1'b1}}};
         w_sat_now = 1'b1;
      end else if (w_tmp[lp_W:lp_W-1] == 2'b10) begin
         w_clamp   = {1'b1, {(lp_W-1){1'b0}}};
         w_sat_now = 1'b1;
      end
   end

   assign w_last  = (r_cnt == lp_CW'(p_COUNT - 1));
   assign o_READY = (r_state == S_ACCUM) && i_RST_N;

   always_ff @(posedge i_CLK) begin
      if (!i_RST_N) begin
         r_state    <= S_ACCUM;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_sat      <= 1'b0;
         o_VALID    <= 1'b0;
         o_SUM      <= '0;
         o_OVERFLOW <= 1'b0;
      end else begin
         case (r_state)
            S_ACCUM: begin
               if (i_VALID) begin
                  if (w_last) begin
                     o_SUM      <= w_clamp;
                     o_OVERFLOW <= r_sat | w_sat_now;
                     o_VALID    <= 1'b1;
                     r_state    <= S_HOLD;
                     r_acc      <= '0;
                     r_cnt      <= '0;
                     r_sat      <= 1'b0;
                  end else begin
                     r_acc <= w_clamp;
                     r_cnt <= r_cnt + lp_CW'(1);
                     r_sat <= r_sat | w_sat_now;
                  end
               end
            end
            default: begin
               // In HOLD o_VALID is always high, so i_READY alone completes the handshake.
               if (i_READY) begin
                  o_VALID <= 1'b0;
                  r_state <= S_ACCUM;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signed_block_accumulator.sv
// tb/tb_signed_block_accumulator.sv - directed self-checking bench for signed_block_accumulator
module tb_signed_block_accumulator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       out_ready = 1'b0;

   logic        d_ready, d_valid, d_ovf;
   logic [15:0] d_sum;
   logic        s_ready, s_valid, s_ovf;
   logic [9:0]  s_sum;
   logic        o1_ready, o1_valid, o1_ovf;
   logic [15:0] o1_sum;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   signed_block_accumulator u_dut (
      .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(in_valid), .o_READY(d_ready),
      .i_DATA(in_data), .o_VALID(d_valid), .i_READY(out_ready),
      .o_SUM(d_sum), .o_OVERFLOW(d_ovf)
   );

   signed_block_accumulator #(.p_INPUT_WIDTH(8), .p_OUTPUT_WIDTH(10), .p_COUNT(8)) u_sat (
      .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(in_valid), .o_READY(s_ready),
      .i_DATA(in_data), .o_VALID(s_valid), .i_READY(out_ready),
      .o_SUM(s_sum), .o_OVERFLOW(s_ovf)
   );

   signed_block_accumulator #(.p_INPUT_WIDTH(8), .p_OUTPUT_WIDTH(16), .p_COUNT(1)) u_one (
      .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(in_valid), .o_READY(o1_ready),
      .i_DATA(in_data), .o_VALID(o1_valid), .i_READY(out_ready),
      .o_SUM(o1_sum), .o_OVERFLOW(o1_ovf)
   );

   function automatic logic rdy(input int sel);
      case (sel)
         0: rdy = d_ready;
         1: rdy = s_ready;
         default: rdy = o1_ready;
      endcase
   endfunction

   // Presents one sample at a negedge and returns once the selected instance is
   // ready, so the transfer happens on the following posedge.
   task automatic send(input logic [7:0] v, input int sel);
      int k;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
      k = 0;
      while (!rdy(sel) && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k == 50) begin
         checks++;
         errors++;
         $display("FAIL send_timeout sel=%0d ready stayed low, required 1", sel);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic take_sum();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(negedge clk);
      checks++;
      if ({d_valid, d_sum, d_ovf, d_ready} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b s=%h o=%b r=%b required all 0", d_valid, d_sum, d_ovf, d_ready);
      end
      checks++;
      if ({s_ready, o1_ready, s_valid, o1_valid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_others got %b required 0000", {s_ready, o1_ready, s_valid, o1_valid});
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      checks++;
      if (d_ready !== 1'b1 || d_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got r=%b v=%b required r=1 v=0", d_ready, d_valid);
      end
   endtask

   task automatic test_mixed_sign();
      logic [7:0] vals [4];
      vals[0] = 8'h7F; vals[1] = 8'h80; vals[2] = 8'hFF; vals[3] = 8'h01;
      do_reset();
      for (int i = 0; i < 4; i++) send(vals[i], 0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (d_valid !== 1'b1 || d_sum !== 16'hFFFF || d_ovf !== 1'b0) begin
         errors++;
         $display("FAIL mixed_sum got v=%b s=%h o=%b required v=1 s=ffff o=0", d_valid, d_sum, d_ovf);
      end
      @(negedge clk);
      checks++;
      if (d_ready !== 1'b0 || d_valid !== 1'b1) begin
         errors++;
         $display("FAIL mixed_hold got r=%b v=%b required r=0 v=1", d_ready, d_valid);
      end
      take_sum();
      checks++;
      if (d_ready !== 1'b1 || d_valid !== 1'b0) begin
         errors++;
         $display("FAIL mixed_release got r=%b v=%b required r=1 v=0", d_ready, d_valid);
      end
   endtask

   task automatic test_saturation();
      logic [7:0] pat [3];
      logic [9:0] exp_sum [3];
      logic       exp_ovf [3];
      pat[0] = 8'h7F; exp_sum[0] = 10'h1FF; exp_ovf[0] = 1'b1;
      pat[1] = 8'h80; exp_sum[1] = 10'h200; exp_ovf[1] = 1'b1;
      pat[2] = 8'h01; exp_sum[2] = 10'h008; exp_ovf[2] = 1'b0;
      do_reset();
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 8; i++) send(pat[b], 1);
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (s_valid !== 1'b1 || s_sum !== exp_sum[b] || s_ovf !== exp_ovf[b]) begin
            errors++;
            $display("FAIL saturation_blk%0d got v=%b s=%h o=%b required v=1 s=%h o=%b",
                     b, s_valid, s_sum, s_ovf, exp_sum[b], exp_ovf[b]);
         end
         take_sum();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 4; i++) send(8'h01, 0);
      @(negedge clk);
      in_data = 8'h05;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (d_valid !== 1'b1 || d_sum !== 16'h0004 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold%0d got v=%b s=%h r=%b required v=1 s=0004 r=0",
                     i, d_valid, d_sum, d_ready);
         end
         @(negedge clk);
      end
      take_sum();
      // in_valid stays high with 0x05 continuously from here on
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (d_valid !== 1'b0 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_next%0d got v=%b r=%b required v=0 r=1", i, d_valid, d_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (d_valid !== 1'b1 || d_sum !== 16'h0014) begin
         errors++;
         $display("FAIL backpressure_sum got v=%b s=%h required v=1 s=0014", d_valid, d_sum);
      end
      take_sum();
   endtask

   task automatic test_gaps();
      logic [6:0] vpat;
      logic [7:0] nxt;
      vpat = 7'b1001011;
      nxt  = 8'h01;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checks++;
         if (d_valid !== 1'b0) begin
            errors++;
            $display("FAIL gaps_early%0d got v=%b required 0", i, d_valid);
         end
         in_valid = vpat[6-i];
         in_data  = vpat[6-i] ? nxt : 8'hEE;
         if (vpat[6-i]) nxt = nxt + 8'h01;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (d_valid !== 1'b1 || d_sum !== 16'h000A) begin
         errors++;
         $display("FAIL gaps_sum got v=%b s=%h required v=1 s=000a", d_valid, d_sum);
      end
      take_sum();
   endtask

   task automatic test_reset_mid_block();
      int extra;
      do_reset();
      send(8'h10, 0);
      send(8'h10, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      checks++;
      if ({d_valid, d_sum, d_ovf, d_ready} !== 19'd0) begin
         errors++;
         $display("FAIL midreset_outputs got v=%b s=%h o=%b r=%b required all 0", d_valid, d_sum, d_ovf, d_ready);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) send(8'h01, 0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (d_valid !== 1'b1 || d_sum !== 16'h0004) begin
         errors++;
         $display("FAIL midreset_sum got v=%b s=%h required v=1 s=0004", d_valid, d_sum);
      end
      take_sum();
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         if (d_valid) extra++;
         @(negedge clk);
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL midreset_extra got %0d extra valid cycles required 0", extra);
      end
   endtask

   task automatic test_count_one();
      do_reset();
      send(8'h80, 2);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (o1_valid !== 1'b1 || o1_sum !== 16'hFF80 || o1_ovf !== 1'b0) begin
         errors++;
         $display("FAIL count1_neg got v=%b s=%h o=%b required v=1 s=ff80 o=0", o1_valid, o1_sum, o1_ovf);
      end
      take_sum();
      send(8'h7F, 2);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (o1_valid !== 1'b1 || o1_sum !== 16'h007F || o1_ovf !== 1'b0) begin
         errors++;
         $display("FAIL count1_pos got v=%b s=%h o=%b required v=1 s=007f o=0", o1_valid, o1_sum, o1_ovf);
      end
      take_sum();
   endtask

   initial begin
      test_reset();
      test_mixed_sign();
      test_saturation();
      test_backpressure();
      test_gaps();
      test_reset_mid_block();
      test_count_one();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
